// File: rtl/pcap_pkg.sv
// Shared types and constants for the pcap record framer.
package pcap_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RECV    = 3'd1,
    HDR     = 3'd2,
    PAYLOAD = 3'd3,
    TRIGGER = 3'd4
  } state_t;

  localparam int unsigned PCAP_HDR_BYTES = 16;
  localparam int unsigned PCAP_HDR_WORDS = 4;

  typedef struct packed {
    logic [31:0] ts_sec;
    logic [31:0] ts_nsec;
    logic [31:0] incl_len;
    logic [31:0] orig_len;
  } pcap_hdr_t;

  // Saturating add of a small increment to a 16-bit event counter.
  function automatic logic [15:0] sat_add16(input logic [15:0] v, input logic [1:0] amt);
    logic [16:0] s;
    s = {1'b0, v} + {15'd0, amt};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

endpackage

// File: rtl/pkt_buf.sv
// Simple dual-port payload buffer, registered read with one cycle of latency.
module pkt_buf #(
  parameter int DEPTH = 512
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [31:0]              wdata,
  input  logic                     re,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [31:0]              rdata
);

  logic [31:0] mem [DEPTH];

  // Write port: store one payload word per accepted beat.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Read port: data appears the cycle after re.
  always_ff @(posedge clk) begin
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/pcap_framer.sv
// pcap_framer: buffers one MAC frame, emits a pcap record into the capture
// FIFO, then hands the record length to wr_ctrl with a one-cycle request.
module pcap_framer
  import pcap_pkg::*;
#(
  parameter int SNAPLEN   = 2048,
  parameter int BUF_DEPTH = 512,
  parameter int FIFO_AW   = 9
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [31:0]        st_data,
  input  logic               st_valid,
  input  logic               st_sop,
  input  logic               st_eop,
  input  logic [1:0]         st_empty,
  input  logic               st_error,
  output logic               st_ready,
  input  logic [31:0]        seconds,
  input  logic [31:0]        nanoseconds,
  output logic [31:0]        fifo_data,
  output logic               fifo_wrreq,
  input  logic               fifo_almost_full,
  input  logic [FIFO_AW-1:0] fifo_usedw,
  output logic               wr_ctrl,
  output logic [31:0]        pkt_begin,
  output logic [31:0]        pkt_end,
  input  logic               wr_ctrl_rdy,
  output logic [15:0]        drop_cnt,
  output logic [15:0]        trunc_cnt
);

  localparam int BAW = $clog2(BUF_DEPTH);
  localparam int WCW = BAW + 1;
  localparam logic [WCW-1:0] SNAP_WORDS = WCW'(SNAPLEN / 4);
  localparam logic [15:0]    SNAP_BYTES = 16'(SNAPLEN);

  state_t         state_r, state_n;
  logic           st_ready_r, st_ready_n;
  logic [31:0]    ts_sec_r, ts_sec_n, ts_nsec_r, ts_nsec_n;
  logic [WCW-1:0] wr_cnt_r, wr_cnt_n, rd_cnt_r, rd_cnt_n;
  logic [15:0]    orig_len_r, orig_len_n, incl_len_r, incl_len_n;
  logic [1:0]     hdr_idx_r, hdr_idx_n;
  logic           rd_valid_r;
  logic [31:0]    fifo_data_r, fifo_data_n;
  logic           fifo_wrreq_r, fifo_wrreq_n;
  logic [31:0]    pkt_end_r, pkt_end_n;
  logic [15:0]    drop_cnt_r, drop_cnt_n, trunc_cnt_r, trunc_cnt_n;
  logic [1:0]     drop_amt_s, trunc_amt_s;
  logic           wr_ctrl_s;

  logic           buf_we_s, buf_re_s;
  logic [BAW-1:0] buf_waddr_s, buf_raddr_s;
  logic [31:0]    buf_rdata_s;

  logic           beat_s, over_snap_s;
  logic [WCW-1:0] base_words_s, pay_words_s;
  logic [15:0]    base_orig_s, new_orig_s;
  logic [2:0]     beat_bytes_s;
  logic [16:0]    orig_sum_s, incl_p3_s;
  logic [31:0]    rec_len_s;
  pcap_hdr_t      hdr_s;
  logic           unused_ok;

  // A sop beat restarts the byte/word accounting; later beats accumulate.
  assign beat_s       = st_valid && st_ready_r;
  assign base_words_s = st_sop ? {WCW{1'b0}} : wr_cnt_r;
  assign base_orig_s  = st_sop ? 16'd0 : orig_len_r;
  assign beat_bytes_s = st_eop ? (3'd4 - {1'b0, st_empty}) : 3'd4;
  assign orig_sum_s   = {1'b0, base_orig_s} + {14'd0, beat_bytes_s};
  assign new_orig_s   = orig_sum_s[16] ? 16'hFFFF : orig_sum_s[15:0];
  assign over_snap_s  = new_orig_s > SNAP_BYTES;

  // Payload is padded up to whole words in the record.
  assign incl_p3_s   = {1'b0, incl_len_r} + 17'd3;
  assign pay_words_s = incl_p3_s[WCW+1:2];
  assign rec_len_s   = 32'(PCAP_HDR_BYTES) + {15'd0, incl_p3_s[16:2], 2'b00};
  assign hdr_s       = '{ts_sec: ts_sec_r, ts_nsec: ts_nsec_r,
                         incl_len: {16'd0, incl_len_r}, orig_len: {16'd0, orig_len_r}};

  assign unused_ok = ^{fifo_usedw, incl_p3_s[1:0]};

  pkt_buf #(.DEPTH(BUF_DEPTH)) u_pkt_buf (
    .clk   (clk),
    .we    (buf_we_s),
    .waddr (buf_waddr_s),
    .wdata (st_data),
    .re    (buf_re_s),
    .raddr (buf_raddr_s),
    .rdata (buf_rdata_s)
  );

  // Next-state and datapath decisions for receive, header, payload and trigger.
  always_comb begin
    state_n      = state_r;
    ts_sec_n     = ts_sec_r;
    ts_nsec_n    = ts_nsec_r;
    wr_cnt_n     = wr_cnt_r;
    rd_cnt_n     = rd_cnt_r;
    orig_len_n   = orig_len_r;
    incl_len_n   = incl_len_r;
    hdr_idx_n    = hdr_idx_r;
    fifo_data_n  = fifo_data_r;
    fifo_wrreq_n = 1'b0;
    pkt_end_n    = pkt_end_r;
    drop_amt_s   = 2'd0;
    trunc_amt_s  = 2'd0;
    wr_ctrl_s    = 1'b0;
    buf_we_s     = 1'b0;
    buf_waddr_s  = base_words_s[BAW-1:0];
    buf_re_s     = 1'b0;
    buf_raddr_s  = rd_cnt_r[BAW-1:0];

    case (state_r)
      IDLE, RECV: begin
        if (beat_s && (st_sop || state_r == RECV)) begin
          if (st_sop) begin
            ts_sec_n  = seconds;
            ts_nsec_n = nanoseconds;
          end else begin
            ts_sec_n  = ts_sec_r;
          end
          if (st_sop && state_r == RECV) begin
            drop_amt_s = 2'd1;
          end else begin
            drop_amt_s = 2'd0;
          end
          if (base_words_s < SNAP_WORDS) begin
            buf_we_s = 1'b1;
            wr_cnt_n = base_words_s + WCW'(1);
          end else begin
            wr_cnt_n = base_words_s;
          end
          orig_len_n = new_orig_s;
          if (st_eop && st_error) begin
            drop_amt_s = drop_amt_s + 2'd1;
            state_n    = IDLE;
          end else if (st_eop) begin
            incl_len_n  = over_snap_s ? SNAP_BYTES : new_orig_s;
            trunc_amt_s = over_snap_s ? 2'd1 : 2'd0;
            hdr_idx_n   = 2'd0;
            state_n     = HDR;
          end else begin
            state_n = RECV;
          end
        end else begin
          state_n = state_r;
        end
      end
      HDR: begin
        if (!fifo_almost_full) begin
          fifo_wrreq_n = 1'b1;
          case (hdr_idx_r)
            2'd0:    fifo_data_n = hdr_s.ts_sec;
            2'd1:    fifo_data_n = hdr_s.ts_nsec;
            2'd2:    fifo_data_n = hdr_s.incl_len;
            default: fifo_data_n = hdr_s.orig_len;
          endcase
          hdr_idx_n = hdr_idx_r + 2'd1;
          if (hdr_idx_r == 2'(PCAP_HDR_WORDS - 1)) begin
            rd_cnt_n = {WCW{1'b0}};
            state_n  = PAYLOAD;
          end else begin
            state_n = HDR;
          end
        end else begin
          fifo_wrreq_n = 1'b0;
        end
      end
      PAYLOAD: begin
        if (rd_valid_r) begin
          fifo_wrreq_n = 1'b1;
          fifo_data_n  = buf_rdata_s;
        end else begin
          fifo_wrreq_n = 1'b0;
        end
        if (rd_cnt_r < pay_words_s) begin
          if (!fifo_almost_full) begin
            buf_re_s = 1'b1;
            rd_cnt_n = rd_cnt_r + WCW'(1);
          end else begin
            buf_re_s = 1'b0;
          end
        end else if (!rd_valid_r) begin
          state_n = TRIGGER;
        end else begin
          state_n = PAYLOAD;
        end
      end
      TRIGGER: begin
        if (wr_ctrl_rdy && !reset) begin
          wr_ctrl_s = 1'b1;
          pkt_end_n = rec_len_s;
          state_n   = IDLE;
        end else begin
          wr_ctrl_s = 1'b0;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase

    st_ready_n  = (state_n == IDLE) || (state_n == RECV);
    drop_cnt_n  = sat_add16(drop_cnt_r, drop_amt_s);
    trunc_cnt_n = sat_add16(trunc_cnt_r, trunc_amt_s);
  end

  // State, datapath and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= IDLE;
      st_ready_r   <= 1'b0;
      ts_sec_r     <= 32'd0;
      ts_nsec_r    <= 32'd0;
      wr_cnt_r     <= {WCW{1'b0}};
      rd_cnt_r     <= {WCW{1'b0}};
      orig_len_r   <= 16'd0;
      incl_len_r   <= 16'd0;
      hdr_idx_r    <= 2'd0;
      rd_valid_r   <= 1'b0;
      fifo_data_r  <= 32'd0;
      fifo_wrreq_r <= 1'b0;
      pkt_end_r    <= 32'd0;
      drop_cnt_r   <= 16'd0;
      trunc_cnt_r  <= 16'd0;
    end else begin
      state_r      <= state_n;
      st_ready_r   <= st_ready_n;
      ts_sec_r     <= ts_sec_n;
      ts_nsec_r    <= ts_nsec_n;
      wr_cnt_r     <= wr_cnt_n;
      rd_cnt_r     <= rd_cnt_n;
      orig_len_r   <= orig_len_n;
      incl_len_r   <= incl_len_n;
      hdr_idx_r    <= hdr_idx_n;
      rd_valid_r   <= buf_re_s;
      fifo_data_r  <= fifo_data_n;
      fifo_wrreq_r <= fifo_wrreq_n;
      pkt_end_r    <= pkt_end_n;
      drop_cnt_r   <= drop_cnt_n;
      trunc_cnt_r  <= trunc_cnt_n;
    end
  end

  // The wr_ctrl request is taken in the very cycle wr_ctrl_rdy is seen, so
  // the pulse and its length are driven straight from the TRIGGER decision.
  assign st_ready   = st_ready_r;
  assign fifo_data  = fifo_data_r;
  assign fifo_wrreq = fifo_wrreq_r;
  assign wr_ctrl    = wr_ctrl_s;
  assign pkt_begin  = 32'd0;
  assign pkt_end    = wr_ctrl_s ? rec_len_s : pkt_end_r;
  assign drop_cnt   = drop_cnt_r;
  assign trunc_cnt  = trunc_cnt_r;

endmodule

// File: tb/tb_pcap_framer.sv
// Directed testbench for pcap_framer: one task per scenario, inline checks.
module tb_pcap_framer;

  localparam int SNAPLEN = 2048;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] st_data = 32'd0;
  logic        st_valid = 1'b0, st_sop = 1'b0, st_eop = 1'b0, st_error = 1'b0;
  logic [1:0]  st_empty = 2'd0;
  logic        st_ready;
  logic [31:0] seconds = 32'd0, nanoseconds = 32'd0;
  logic [31:0] fifo_data;
  logic        fifo_wrreq;
  logic        fifo_almost_full = 1'b0;
  logic [8:0]  fifo_usedw = 9'd0;
  logic        wr_ctrl;
  logic [31:0] pkt_begin, pkt_end;
  logic        wr_ctrl_rdy = 1'b1;
  logic [15:0] drop_cnt, trunc_cnt;

  pcap_framer #(.SNAPLEN(SNAPLEN), .BUF_DEPTH(512), .FIFO_AW(9)) dut (
    .clk(clk), .reset(reset), .st_data(st_data), .st_valid(st_valid), .st_sop(st_sop),
    .st_eop(st_eop), .st_empty(st_empty), .st_error(st_error), .st_ready(st_ready),
    .seconds(seconds), .nanoseconds(nanoseconds), .fifo_data(fifo_data),
    .fifo_wrreq(fifo_wrreq), .fifo_almost_full(fifo_almost_full), .fifo_usedw(fifo_usedw),
    .wr_ctrl(wr_ctrl), .pkt_begin(pkt_begin), .pkt_end(pkt_end), .wr_ctrl_rdy(wr_ctrl_rdy),
    .drop_cnt(drop_cnt), .trunc_cnt(trunc_cnt)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail = 0;
  int          cyc = 0;
  logic [31:0] fifo_q[$];
  int          pulse_cnt = 0;
  int          pulse_cyc = 0;
  logic [31:0] last_end = 32'd0, last_begin = 32'd0;
  logic [31:0] sent_q[$];
  logic [31:0] exp_q[$];
  logic [31:0] sop_sec, sop_nsec;

  // Cycle counter advanced on the active edge.
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: capture FIFO writes and wr_ctrl pulses on the falling edge.
  always @(negedge clk) begin
    if (fifo_wrreq) fifo_q.push_back(fifo_data);
    if (wr_ctrl) begin
      pulse_cnt  = pulse_cnt + 1;
      pulse_cyc  = cyc;
      last_end   = pkt_end;
      last_begin = pkt_begin;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one frame of nbytes with an incrementing byte pattern.
  task automatic send_frame(input int nbytes, input bit err, input logic [7:0] seed);
    int nbeats;
    int guard;
    logic [7:0] b;
    logic [31:0] word;
    nbeats = (nbytes + 3) / 4;
    sent_q.delete();
    sop_sec  = 32'h5A00_0000 + {24'd0, seed};
    sop_nsec = 32'h0123_0000 + {16'd0, seed, 8'h00};
    for (int i = 0; i < nbeats; i++) begin
      b = seed + 8'(4 * i);
      word = {b + 8'd3, b + 8'd2, b + 8'd1, b};
      st_data     = word;
      st_valid    = 1'b1;
      st_sop      = (i == 0);
      st_eop      = (i == nbeats - 1);
      st_empty    = (i == nbeats - 1) ? 2'((nbeats * 4 - nbytes) & 3) : 2'd0;
      st_error    = (i == nbeats - 1) && err;
      seconds     = (i == 0) ? sop_sec : sop_sec + 32'(i);
      nanoseconds = (i == 0) ? sop_nsec : sop_nsec + 32'(7 * i);
      guard = 0;
      while (!st_ready && guard < 1000) begin
        tick();
        guard++;
      end
      if (guard >= 1000) begin
        n_checks++; n_fail++;
        $display("FAIL st_ready_timeout: beat %0d never accepted", i);
        break;
      end
      sent_q.push_back(word);
      tick();
    end
    st_valid = 1'b0; st_sop = 1'b0; st_eop = 1'b0; st_error = 1'b0; st_empty = 2'd0;
  endtask

  // Model: expected record words for the last frame sent.
  task automatic build_expected(input int nbytes);
    int incl, orig, nw;
    incl = (nbytes > SNAPLEN) ? SNAPLEN : nbytes;
    orig = (nbytes > 65535) ? 65535 : nbytes;
    nw   = (incl + 3) / 4;
    exp_q.delete();
    exp_q.push_back(sop_sec);
    exp_q.push_back(sop_nsec);
    exp_q.push_back(32'(incl));
    exp_q.push_back(32'(orig));
    for (int i = 0; i < nw; i++) exp_q.push_back(sent_q[i]);
  endtask

  task automatic wait_pulse(input int target, input int budget);
    int k;
    k = 0;
    while (pulse_cnt < target && k < budget) begin
      tick();
      k++;
    end
    if (pulse_cnt < target) begin
      n_checks++; n_fail++;
      $display("FAIL wr_ctrl_timeout: pulses %0d, required %0d", pulse_cnt, target);
    end
  endtask

  task automatic wait_words(input int target, input int budget);
    int k;
    k = 0;
    while (fifo_q.size() < target && k < budget) begin
      tick();
      k++;
    end
    if (fifo_q.size() < target) begin
      n_checks++; n_fail++;
      $display("FAIL fifo_timeout: words %0d, required %0d", fifo_q.size(), target);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
    n_checks++; if (st_ready !== 1'b0) begin n_fail++; $display("FAIL rst_st_ready: got %b want 0", st_ready); end
    n_checks++; if (fifo_wrreq !== 1'b0) begin n_fail++; $display("FAIL rst_wrreq: got %b want 0", fifo_wrreq); end
    n_checks++; if (fifo_data !== 32'd0) begin n_fail++; $display("FAIL rst_data: got %h want 0", fifo_data); end
    n_checks++; if (wr_ctrl !== 1'b0) begin n_fail++; $display("FAIL rst_wr_ctrl: got %b want 0", wr_ctrl); end
    n_checks++; if (pkt_end !== 32'd0 || pkt_begin !== 32'd0) begin n_fail++; $display("FAIL rst_pkt: got %0d/%0d want 0/0", pkt_begin, pkt_end); end
    n_checks++; if (drop_cnt !== 16'd0 || trunc_cnt !== 16'd0) begin n_fail++; $display("FAIL rst_cnt: got %0d/%0d want 0/0", drop_cnt, trunc_cnt); end
    reset = 1'b0;
    tick();
    n_checks++; if (st_ready !== 1'b1) begin n_fail++; $display("FAIL idle_st_ready: got %b want 1", st_ready); end
  endtask

  // Good frame of nbytes with wr_ctrl_rdy high; checks record and pulse.
  task automatic test_frame(input string name, input int nbytes, input logic [7:0] seed,
                            input logic [31:0] exp_end);
    int base, p0;
    logic [31:0] got;
    wr_ctrl_rdy = 1'b1;
    base = fifo_q.size();
    p0 = pulse_cnt;
    send_frame(nbytes, 1'b0, seed);
    build_expected(nbytes);
    wait_pulse(p0 + 1, 3000);
    repeat (4) tick();
    n_checks++; if (pulse_cnt !== p0 + 1) begin n_fail++; $display("FAIL %s_pulses: got %0d want %0d", name, pulse_cnt - p0, 1); end
    n_checks++; if (last_end !== exp_end) begin n_fail++; $display("FAIL %s_pkt_end: got %0d want %0d", name, last_end, exp_end); end
    n_checks++; if (last_begin !== 32'd0) begin n_fail++; $display("FAIL %s_pkt_begin: got %0d want 0", name, last_begin); end
    n_checks++; if (pkt_end !== exp_end) begin n_fail++; $display("FAIL %s_pkt_end_hold: got %0d want %0d", name, pkt_end, exp_end); end
    n_checks++; if (fifo_q.size() - base !== exp_q.size()) begin n_fail++; $display("FAIL %s_words: got %0d want %0d", name, fifo_q.size() - base, exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      got = (base + i < fifo_q.size()) ? fifo_q[base + i] : 32'hDEAD_BEEF;
      n_checks++; if (got !== exp_q[i]) begin n_fail++; $display("FAIL %s_word%0d: got %h want %h", name, i, got, exp_q[i]); end
    end
  endtask

  task automatic test_trunc();
    test_frame("trunc3000", 3000, 8'h21, 32'd2064);
    n_checks++; if (trunc_cnt !== 16'd1) begin n_fail++; $display("FAIL trunc_cnt: got %0d want 1", trunc_cnt); end
  endtask

  task automatic test_error();
    int base, p0;
    base = fifo_q.size();
    p0 = pulse_cnt;
    send_frame(40, 1'b1, 8'h77);
    repeat (30) tick();
    n_checks++; if (fifo_q.size() !== base) begin n_fail++; $display("FAIL err_words: got %0d want 0", fifo_q.size() - base); end
    n_checks++; if (pulse_cnt !== p0) begin n_fail++; $display("FAIL err_pulse: got %0d want 0", pulse_cnt - p0); end
    n_checks++; if (drop_cnt !== 16'd1) begin n_fail++; $display("FAIL err_drop_cnt: got %0d want 1", drop_cnt); end
    test_frame("after_err", 64, 8'h90, 32'd80);
  endtask

  task automatic test_stall();
    int base, p0, rdy_cyc;
    logic [31:0] got;
    base = fifo_q.size();
    p0 = pulse_cnt;
    rdy_cyc = -1;
    wr_ctrl_rdy = 1'b0;
    fork
      send_frame(64, 1'b0, 8'h40);
      begin
        wait_words(base + 8, 500);
        fifo_almost_full = 1'b1;
        repeat (5) tick();
        fifo_almost_full = 1'b0;
        wait_words(base + 20, 500);
        repeat (10) tick();
        n_checks++; if (pulse_cnt !== p0) begin n_fail++; $display("FAIL stall_early_pulse: got %0d want 0", pulse_cnt - p0); end
        wr_ctrl_rdy = 1'b1;
        rdy_cyc = cyc;
      end
    join
    build_expected(64);
    wait_pulse(p0 + 1, 100);
    repeat (4) tick();
    n_checks++; if (pulse_cnt !== p0 + 1) begin n_fail++; $display("FAIL stall_pulses: got %0d want 1", pulse_cnt - p0); end
    n_checks++; if (pulse_cyc !== rdy_cyc) begin n_fail++; $display("FAIL stall_pulse_cycle: got %0d want %0d", pulse_cyc, rdy_cyc); end
    n_checks++; if (last_end !== 32'd80) begin n_fail++; $display("FAIL stall_pkt_end: got %0d want 80", last_end); end
    n_checks++; if (fifo_q.size() - base !== exp_q.size()) begin n_fail++; $display("FAIL stall_words: got %0d want %0d", fifo_q.size() - base, exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      got = (base + i < fifo_q.size()) ? fifo_q[base + i] : 32'hDEAD_BEEF;
      n_checks++; if (got !== exp_q[i]) begin n_fail++; $display("FAIL stall_word%0d: got %h want %h", i, got, exp_q[i]); end
    end
  endtask

  task automatic test_reset_mid();
    int base, p0;
    wr_ctrl_rdy = 1'b1;
    base = fifo_q.size();
    p0 = pulse_cnt;
    send_frame(64, 1'b0, 8'hC0);
    wait_words(base + 8, 200);
    reset = 1'b1;
    tick();
    n_checks++; if (st_ready !== 1'b0 || fifo_wrreq !== 1'b0) begin n_fail++; $display("FAIL mid_rst_ctl: got ready=%b wrreq=%b want 0/0", st_ready, fifo_wrreq); end
    n_checks++; if (fifo_data !== 32'd0) begin n_fail++; $display("FAIL mid_rst_data: got %h want 0", fifo_data); end
    n_checks++; if (wr_ctrl !== 1'b0 || pkt_end !== 32'd0 || pkt_begin !== 32'd0) begin n_fail++; $display("FAIL mid_rst_pkt: got %b/%0d/%0d want 0/0/0", wr_ctrl, pkt_begin, pkt_end); end
    n_checks++; if (drop_cnt !== 16'd0 || trunc_cnt !== 16'd0) begin n_fail++; $display("FAIL mid_rst_cnt: got %0d/%0d want 0/0", drop_cnt, trunc_cnt); end
    reset = 1'b0;
    repeat (30) tick();
    n_checks++; if (pulse_cnt !== p0) begin n_fail++; $display("FAIL mid_rst_pulse: got %0d want 0", pulse_cnt - p0); end
    test_frame("post_rst", 64, 8'h05, 32'd80);
  endtask

  initial begin
    test_reset();
    test_frame("frame64", 64, 8'h10, 32'd80);
    test_frame("frame61", 61, 8'h33, 32'd80);
    test_trunc();
    test_error();
    test_stall();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
